// File: rtl/bank_array.sv
// Banked word memory with byte-enable writes, 1-cycle write-first reads, and a
// post-reset clear sweep that zeroes every bank before requests are accepted.
module bank_array #(
    parameter int DATA_W = 128,
    parameter int ADDR_W = 7,
    parameter int BANK_W = 2
) (
    input  logic                       vsi_clk,
    input  logic                       vsi_reset,
    input  logic                       vsi_inputChipSelect,
    input  logic [BANK_W+ADDR_W-1:0]   vsi_inputAddr,
    input  logic [DATA_W-1:0]          vsi_inputData,
    input  logic [DATA_W/8-1:0]        vsi_inputByteEn,
    input  logic                       vsi_outputChipSelect,
    input  logic [BANK_W+ADDR_W-1:0]   vsi_outputAddr,
    output logic [DATA_W-1:0]          vsi_outputData,
    output logic                       vsi_outputValid,
    output logic                       vsi_ready
);

    localparam int unsigned DEPTH     = 2 ** ADDR_W;
    localparam int unsigned NUM_BANKS = 2 ** BANK_W;
    localparam int unsigned BYTES     = DATA_W / 8;

    typedef enum logic {CLEAR, READY} stateT;

    stateT              state;
    logic [ADDR_W-1:0]  clearCnt;
    logic [DATA_W-1:0]  mem [NUM_BANKS*DEPTH];
    logic               writeEn;
    logic [DATA_W-1:0]  readWord;

    assign writeEn = (state == READY) && vsi_inputChipSelect;

    // Write-first bypass: a same-address write in this cycle overrides its enabled bytes.
    always_comb begin
        readWord = mem[vsi_outputAddr];
        if (writeEn && (vsi_inputAddr == vsi_outputAddr)) begin
            for (int unsigned i = 0; i < BYTES; i++) begin
                if (vsi_inputByteEn[i])
                    readWord[8*i +: 8] = vsi_inputData[8*i +: 8];
            end
        end
    end

    always_ff @(posedge vsi_clk) begin
        if (!vsi_reset) begin
            if (state == CLEAR) begin
                for (int unsigned b = 0; b < NUM_BANKS; b++)
                    mem[{BANK_W'(b), clearCnt}] <= '0;
            end else if (vsi_inputChipSelect) begin
                for (int unsigned i = 0; i < BYTES; i++) begin
                    if (vsi_inputByteEn[i])
                        mem[vsi_inputAddr][8*i +: 8] <= vsi_inputData[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge vsi_clk) begin
        if (vsi_reset) begin
            state           <= CLEAR;
            clearCnt        <= '0;
            vsi_outputData  <= '0;
            vsi_outputValid <= 1'b0;
            vsi_ready       <= 1'b0;
        end else begin
            case (state)
                CLEAR: begin
                    vsi_outputValid <= 1'b0;
                    clearCnt        <= clearCnt + 1'b1;
                    if (clearCnt == ADDR_W'(DEPTH - 1)) begin
                        state     <= READY;
                        vsi_ready <= 1'b1;
                    end
                end
                READY: begin
                    vsi_ready       <= 1'b1;
                    vsi_outputValid <= vsi_outputChipSelect;
                    if (vsi_outputChipSelect)
                        vsi_outputData <= readWord;
                end
                default: begin
                    state     <= CLEAR;
                    clearCnt  <= '0;
                    vsi_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/bank_array.md
BANK_ARRAY -- requirements
Module: bank_array

Interface
REQ-001 SHALL have parameter DATA_W, default 128, word width in bits (multiple of 8).
REQ-002 SHALL have parameter ADDR_W, default 7, per-bank word address width; bank depth DEPTH = 2^ADDR_W.
REQ-003 SHALL have parameter BANK_W, default 2, bank-select width; NUM_BANKS = 2^BANK_W.
REQ-004 SHALL have port vsi_clk  input  1  single clock; all logic on its rising edge.
REQ-005 SHALL have port vsi_reset  input  1  reset, synchronous and active-high.
REQ-006 SHALL have port vsi_inputChipSelect  input  1  write request.
REQ-007 SHALL have port vsi_inputAddr  input  BANK_W+ADDR_W  write address; MSBs select the bank.
REQ-008 SHALL have port vsi_inputData  input  DATA_W  write data.
REQ-009 SHALL have port vsi_inputByteEn  input  DATA_W/8  write byte enable, active-high; bit i covers data bits [8i+7:8i].
REQ-010 SHALL have port vsi_outputChipSelect  input  1  read request.
REQ-011 SHALL have port vsi_outputAddr  input  BANK_W+ADDR_W  read address.
REQ-012 SHALL have port vsi_outputData  output  DATA_W  read data.
REQ-013 SHALL have port vsi_outputValid  output  1  one-cycle pulse; vsi_outputData holds new read data.
REQ-014 SHALL have port vsi_ready  output  1  high when requests are accepted (READY state).

Function
REQ-015 SHALL implement storage of NUM_BANKS x DEPTH words of DATA_W bits; write and read ports are independent and may each be active every cycle.
REQ-016 SHALL contain a FSM with states CLEAR and READY; reset enters CLEAR with clear counter = 0.
REQ-017 In CLEAR SHALL write all-zero to index = counter in every bank at once, increment counter each cycle, and move to READY in the cycle after index DEPTH-1 is written; CLEAR therefore lasts exactly DEPTH cycles.
REQ-018 In CLEAR SHALL ignore both chip selects; no write takes place, vsi_outputValid stays 0, vsi_ready = 0.
REQ-019 In READY SHALL set vsi_ready = 1 and stay in READY until reset.
REQ-020 A write with vsi_inputChipSelect=1 in READY SHALL update only the enabled bytes of the addressed word at the clock edge; disabled bytes keep their value; byte enable all-zero SHALL leave memory unchanged.
REQ-021 A read with vsi_outputChipSelect=1 in READY SHALL present the addressed word on vsi_outputData with vsi_outputValid=1 exactly one cycle later (latency 1).
REQ-022 When no read is accepted, vsi_outputData SHALL hold its previous value and vsi_outputValid SHALL be 0 in the next cycle.
REQ-023 A read and a write to the same full address in the same cycle SHALL return write-first data: enabled bytes from vsi_inputData, the other bytes from the old stored word.
REQ-024 A read and a write to different addresses (same or different bank) in the same cycle SHALL both complete with no interaction.
REQ-025 Back-to-back reads SHALL give one valid word per cycle, in request order.
REQ-026 Addresses SHALL never go out of range: every value of the address port maps to exactly one word.

Reset
REQ-027 While vsi_reset=1 at a clock edge: FSM goes to CLEAR, counter = 0, vsi_outputData = 0, vsi_outputValid = 0, vsi_ready = 0.
REQ-028 Reset asserted during READY or in the middle of CLEAR SHALL restart CLEAR from index 0; a read pending when reset is sampled SHALL NOT produce vsi_outputValid.
REQ-029 Memory contents are undefined during reset and SHALL all be zero once vsi_ready rises.

Verification
REQ-030 Defaults, release reset, hold all inputs idle -> vsi_ready rises exactly 128 cycles after release; a read of each address of all 4 banks then returns 0.
REQ-031 Write addr 0x1A5 data 0x0123...EF, ByteEn all ones; read 0x1A5 the next cycle -> vsi_outputValid pulse 1 cycle later with the same data; read 0x0A5 -> 0.
REQ-032 Word at 0x010 = all 0xFF; write 0x00...00 with ByteEn=0x0001 -> read returns 0xFF..FF00.
REQ-033 Word at 0x020 = 0xAA..AA; in the same cycle write 0x55..55, ByteEn=0xFF00, and read 0x020 -> read returns 0x55 in upper 8 bytes and 0xAA in lower 8 bytes.
REQ-034 Issue reads on 4 consecutive cycles to 0x000, 0x080, 0x100, 0x180 after writing 1,2,3,4 -> four consecutive valid cycles returning 1,2,3,4.
REQ-035 Assert reset for 1 cycle at clear counter 50, and also during an active read -> no valid pulse; CLEAR restarts; vsi_ready rises 128 cycles after release; memory all zero.
